vga_pic_bounce: RTL

VGA_PIC_BOUNCE -- requirements
Module: vga_pic_bounce

---
 rtl/vga_pic_bounce.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/vga_pic_bounce.sv
// vga_pic_bounce: pixel colour generator with a box that bounces around the
// active area once per frame. Four picture modes: plain box, inverted box,
// colour bars with the box on top, and a checkerboard with the box on top.
// The mode request is latched only at frame end, so a frame is never torn.
// Optional build macro VGA_PIC_BORDER_EN adds a solid border around the
// active area that overrides every mode.
module vga_pic_bounce #(
   parameter int          H_VALID  = 640,
   parameter int          V_VALID  = 480,
   parameter int          COORD_W  = 10,
   parameter int          BOX_W    = 64,
   parameter int          BOX_H    = 48,
   parameter int          STEP     = 2,
   parameter logic [15:0] FG_COLOR = 16'h001F,
   parameter logic [15:0] BG_COLOR = 16'hFFFF
`ifdef VGA_PIC_BORDER_EN
   ,
   parameter int          BORDER_W     = 4,
   parameter logic [15:0] BORDER_COLOR = 16'hF800
`endif
) (
   input  logic               vga_clk,
   input  logic               sys_rst_n,
   input  logic [COORD_W-1:0] pix_x,
   input  logic [COORD_W-1:0] pix_y,
   input  logic [1:0]         mode,
   input  logic               pause,
   output logic [15:0]        pix_data,
   output logic [7:0]         frame_cnt
);

   // Two extra bits so box_pos + size + step can never wrap in compares.
   localparam int EW = COORD_W + 2;

   logic [COORD_W-1:0] boxX_q, boxX_d;
   logic [COORD_W-1:0] boxY_q, boxY_d;
   logic               dirX_q, dirX_d;
   logic               dirY_q, dirY_d;
   logic [1:0]         mode_q;
   logic [7:0]         frameCnt_q;
   logic [15:0]        pixData_q, colour_d;

   logic               frameEnd;
   logic               active;
   logic               inBox;
   logic [COORD_W-1:0] barQuot;
   logic [15:0]        barColour;
   logic [15:0]        checkColour;
   logic [EW-1:0]      pixXE, pixYE, boxXE, boxYE;

   assign pixXE = EW'(pix_x);
   assign pixYE = EW'(pix_y);
   assign boxXE = EW'(boxX_q);
   assign boxYE = EW'(boxY_q);

   assign frameEnd = (pix_x == COORD_W'(H_VALID - 1)) && (pix_y == COORD_W'(V_VALID - 1));
   assign active   = (pixXE < EW'(H_VALID)) && (pixYE < EW'(V_VALID));
   assign inBox    = (pixXE >= boxXE) && (pixXE < boxXE + EW'(BOX_W)) &&
                     (pixYE >= boxYE) && (pixYE < boxYE + EW'(BOX_H));

   // Colour bar index is the pixel column divided into eight equal slices.
   assign barQuot     = pix_x / COORD_W'(H_VALID / 8);
   assign checkColour = (pix_x[5] ^ pix_y[5]) ? 16'h0000 : 16'hFFFF;

   // Map the bar slice to its colour; anything past slice 6 is black.
   always_comb begin
      barColour = 16'h0000;
      case (barQuot)
         COORD_W'(0): barColour = 16'hFFFF;
         COORD_W'(1): barColour = 16'hFFE0;
         COORD_W'(2): barColour = 16'h07FF;
         COORD_W'(3): barColour = 16'h07E0;
         COORD_W'(4): barColour = 16'hF81F;
         COORD_W'(5): barColour = 16'hF800;
         COORD_W'(6): barColour = 16'h001F;
         default:     barColour = 16'h0000;
      endcase
   end

   // Pick the pixel colour from the current mode; blanking area is black.
   always_comb begin
      colour_d = 16'h0000;
      if (active) begin
         case (mode_q)
            2'd0:    colour_d = inBox ? FG_COLOR : BG_COLOR;
            2'd1:    colour_d = inBox ? BG_COLOR : FG_COLOR;
            2'd2:    colour_d = inBox ? FG_COLOR : barColour;
            default: colour_d = inBox ? FG_COLOR : checkColour;
         endcase
`ifdef VGA_PIC_BORDER_EN
         if ((pixXE < EW'(BORDER_W)) || (pixXE >= EW'(H_VALID - BORDER_W)) ||
             (pixYE < EW'(BORDER_W)) || (pixYE >= EW'(V_VALID - BORDER_W)))
            colour_d = BORDER_COLOR;
`endif
      end
   end

   // Next box position: clamp to the wall and reverse instead of overshooting.
   always_comb begin
      boxX_d = boxX_q;
      boxY_d = boxY_q;
      dirX_d = dirX_q;
      dirY_d = dirY_q;
      if (frameEnd && !pause) begin
         if (dirX_q) begin
            if (boxXE + EW'(BOX_W) + EW'(STEP) > EW'(H_VALID)) begin
               boxX_d = COORD_W'(H_VALID - BOX_W);
               dirX_d = 1'b0;
            end else begin
               boxX_d = boxX_q + COORD_W'(STEP);
            end
         end else begin
            if (boxX_q < COORD_W'(STEP)) begin
               boxX_d = '0;
               dirX_d = 1'b1;
            end else begin
               boxX_d = boxX_q - COORD_W'(STEP);
            end
         end
         if (dirY_q) begin
            if (boxYE + EW'(BOX_H) + EW'(STEP) > EW'(V_VALID)) begin
               boxY_d = COORD_W'(V_VALID - BOX_H);
               dirY_d = 1'b0;
            end else begin
               boxY_d = boxY_q + COORD_W'(STEP);
            end
         end else begin
            if (boxY_q < COORD_W'(STEP)) begin
               boxY_d = '0;
               dirY_d = 1'b1;
            end else begin
               boxY_d = boxY_q - COORD_W'(STEP);
            end
         end
      end
   end

   // All state: registered pixel, box motion, frame counter and latched mode.
   always_ff @(posedge vga_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         pixData_q  <= 16'h0000;
         frameCnt_q <= 8'd0;
         boxX_q     <= '0;
         boxY_q     <= '0;
         dirX_q     <= 1'b1;
         dirY_q     <= 1'b1;
         mode_q     <= 2'd0;
      end else begin
         pixData_q <= colour_d;
         boxX_q    <= boxX_d;
         boxY_q    <= boxY_d;
         dirX_q    <= dirX_d;
         dirY_q    <= dirY_d;
         if (frameEnd) begin
            frameCnt_q <= frameCnt_q + 8'd1;
            mode_q     <= mode;
         end
      end
   end

   assign pix_data  = pixData_q;
   assign frame_cnt = frameCnt_q;

endmodule
